// File: rtl/adc_intf.sv
// adc_intf: SPI master for an 8-channel 12-bit ADC128S-style serial ADC.
// One conversion is two 16-bit frames on the same chip select. Frame 1
// sends the channel address. Frame 2 resends it and captures the result.
// The result appears on res together with a one-clock cnv_cmplt strobe.
// Optional feature: define ADC_ERR_EN to add the sticky err output. err
// flags a nonzero upper nibble in the frame-2 word.
module adc_intf #(
  parameter int SCLK_DIV = 32,  // clk cycles per SCLK period (even, >= 4)
  parameter int GAP_CLKS = 16   // clk cycles SS_n stays high between the frames
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt_cnv,
  input  logic [2:0]  chnnl,
  output logic [11:0] res,
  output logic        cnv_cmplt,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
`ifdef ADC_ERR_EN
  ,
  output logic        err
`endif
);

  localparam int H       = SCLK_DIV / 2;
  localparam int CNT_MAX = (SCLK_DIV > GAP_CLKS) ? SCLK_DIV : GAP_CLKS;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
`ifdef ADC_ERR_EN
  localparam int RXW = 16;  // keep the status nibble for the format check
`else
  localparam int RXW = 12;  // only the data bits are ever used
`endif

  typedef logic [CW-1:0] cnt_t;
  typedef enum logic [2:0] {IDLE, FRONT, SHIFT, BACK, GAP, DONE} state_t;

  localparam cnt_t HALF_END = cnt_t'(H - 1);
  localparam cnt_t PER_END  = cnt_t'(SCLK_DIV - 1);
  localparam cnt_t GAP_END  = cnt_t'(GAP_CLKS - 1);

  state_t           state, state_nxt;
  cnt_t             cnt, cnt_nxt;
  logic [3:0]       bit_cnt, bit_nxt;
  logic             frame2, frame2_nxt;
  logic             ss_n_nxt, sclk_nxt, mosi_nxt;
  logic             accept, sample, done;
  logic [2:0]       ch_q;
  logic [RXW-1:0]   rx;
  logic [15:0]      tx;

  // The same address word goes out in both frames.
  assign tx = {2'b00, ch_q, 11'b0};

  // State, timing counters and registered SPI pins.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values. Blocking assignments here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      frame2  <= 1'b0;
      SS_n    <= 1'b1;
      SCLK    <= 1'b1;
      MOSI    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_nxt;
      frame2  <= frame2_nxt;
      SS_n    <= ss_n_nxt;
      SCLK    <= sclk_nxt;
      MOSI    <= mosi_nxt;
    end
  end

  // Next-state logic and next values for the SPI pins.
  // NOTE: every output of this block gets a default first. A path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + 1'b1;
    bit_nxt    = bit_cnt;
    frame2_nxt = frame2;
    ss_n_nxt   = SS_n;
    sclk_nxt   = SCLK;
    mosi_nxt   = MOSI;
    accept     = 1'b0;
    sample     = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nxt  = '0;
        ss_n_nxt = 1'b1;
        sclk_nxt = 1'b1;
        if (strt_cnv) begin
          accept     = 1'b1;
          frame2_nxt = 1'b0;
          state_nxt  = FRONT;
          ss_n_nxt   = 1'b0;
          mosi_nxt   = 1'b0;  // bit 15 of every address word is 0
        end
      end
      FRONT: begin
        if (cnt == HALF_END) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
          bit_nxt   = '0;
          sclk_nxt  = 1'b0;  // first falling edge; MOSI already holds bit 15
        end
      end
      SHIFT: begin
        if (cnt == HALF_END) begin
          sclk_nxt = 1'b1;
          sample   = 1'b1;
        end
        if (cnt == PER_END) begin
          cnt_nxt = '0;
          if (bit_cnt == 4'd15) begin
            state_nxt = BACK;
          end else begin
            bit_nxt  = bit_cnt + 1'b1;
            sclk_nxt = 1'b0;
            mosi_nxt = tx[4'd14 - bit_cnt];
          end
        end
      end
      BACK: begin
        if (cnt == HALF_END) begin
          cnt_nxt   = '0;
          ss_n_nxt  = 1'b1;
          state_nxt = frame2 ? DONE : GAP;
        end
      end
      GAP: begin
        if (cnt == GAP_END) begin
          cnt_nxt    = '0;
          frame2_nxt = 1'b1;
          state_nxt  = FRONT;
          ss_n_nxt   = 1'b0;
          mosi_nxt   = tx[15];
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: channel latch, receive shifter, result and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q      <= '0;
      rx        <= '0;
      res       <= '0;
      cnv_cmplt <= 1'b0;
`ifdef ADC_ERR_EN
      err       <= 1'b0;
`endif
    end else begin
      cnv_cmplt <= done;
      if (accept) ch_q <= chnnl;
      if (sample) rx <= {rx[RXW-2:0], MISO};
      if (done) begin
        res <= rx[11:0];
`ifdef ADC_ERR_EN
        if (rx[15:12] != 4'h0) err <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_adc_intf.sv
// tb_adc_intf: self-checking bench for adc_intf at SCLK_DIV=32, GAP_CLKS=16.
// A transaction-level reference model predicts when cnv_cmplt fires and what
// res must be. A cycle-sampled ADC model watches the SPI pins. It checks
// frame length, the gap, the SCLK edge count and the address word. It also
// answers with the value of the channel addressed in the previous frame.
module tb_adc_intf;

  localparam int D     = 32;
  localparam int G     = 16;
  localparam int FRAME = 544;   // 16 + 16*32 + 16
  localparam int LAT   = 1105;  // 1 + 2*(32*17) + 16

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        strt_cnv = 1'b0;
  logic [2:0]  chnnl = 3'd0;
  logic [11:0] res;
  logic        cnv_cmplt, SS_n, SCLK, MOSI;
  logic        MISO = 1'b0;
`ifdef ADC_ERR_EN
  logic        err;
`endif

  adc_intf #(.SCLK_DIV(D), .GAP_CLKS(G)) dut (
    .clk(clk), .rst_n(rst_n), .strt_cnv(strt_cnv), .chnnl(chnnl),
    .res(res), .cnv_cmplt(cnv_cmplt), .SS_n(SS_n), .SCLK(SCLK),
    .MOSI(MOSI), .MISO(MISO)
`ifdef ADC_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ADC contents and response controls.
  logic [11:0] adc_val [8];
  logic [3:0]  err_nib  = 4'h0;
  logic [2:0]  adc_addr = 3'd0;

  // Transaction-level reference model, advanced once per clock.
  bit          busy = 0;
  int          t = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  logic [2:0]  ch_exp = 3'd0;
  logic        exp_cmplt = 1'b0;
  logic [11:0] exp_res = 12'h000;
  logic        exp_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy = 0; exp_cmplt = 1'b0; exp_res = 12'h000; exp_err = 1'b0;
    end else begin
      cyc++;
      exp_cmplt = 1'b0;
      if (busy) begin
        t++;
        if (t == LAT) begin
          busy = 0;
          exp_cmplt = 1'b1;
          exp_res = adc_val[ch_exp];
          if (err_nib != 4'h0) exp_err = 1'b1;
        end
      end else if (strt_cnv) begin
        busy = 1; t = 0; ch_exp = chnnl; acc_cyc = cyc;
      end
    end
  end

  // Per-cycle output comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("cnv_cmplt", cnv_cmplt, exp_cmplt);
      check("res", res, exp_res);
      if (SS_n) check("sclk_idle", SCLK, 1'b1);
`ifdef ADC_ERR_EN
      check("err", err, exp_err);
`endif
    end
  end

  // ADC pin model and frame-shape checks.
  logic        prev_ss = 1'b1, prev_sclk = 1'b1;
  int          k = 0, low_len = 0, high_len = 0, nrise = 0, frames = 0;
  bit          in_gap = 0;
  logic [15:0] word = '0, rcv = '0, last_rcv = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ss = 1'b1; prev_sclk = 1'b1; MISO = 1'b0; in_gap = 0; frames = 0;
    end else begin
      if (!SS_n && prev_ss) begin
        if (in_gap) check("gap_len", high_len, G);
        in_gap = 0; k = 0; nrise = 0; low_len = 0; rcv = '0;
        word = {err_nib, adc_val[adc_addr]};
      end
      if (!SS_n) begin
        low_len++;
        if (prev_sclk && !SCLK) begin MISO = word[15-k]; k++; end
        if (!prev_sclk && SCLK) begin rcv = {rcv[14:0], MOSI}; nrise++; end
      end
      if (SS_n && !prev_ss) begin
        check("frame_len", low_len, FRAME);
        check("sclk_rises", nrise, 16);
        check("mosi_word", rcv, {2'b00, ch_exp, 11'b0});
        last_rcv = rcv;
        adc_addr = rcv[13:11];
        frames++;
        in_gap = (frames == 1);
        high_len = 0;
        if (frames == 2) frames = 0;
      end
      if (SS_n) high_len++;
      prev_ss = SS_n; prev_sclk = SCLK;
    end
  end

  task automatic wait_cmplt(input string name);
    int seen = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (cnv_cmplt === 1'b1) begin seen = 1; break; end
    end
    check({name, "_cmplt_seen"}, seen, 1);
  endtask

  task automatic request(input logic [2:0] ch, input int hold);
    @(negedge clk);
    chnnl = ch;
    strt_cnv = 1'b1;
    repeat (hold) @(negedge clk);
    strt_cnv = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 2000000", $time);
    $fatal(1);
  end

  initial begin
    logic [2:0] steps [7];
    int last_c;
    logic [2:0] ch;
    steps = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
    for (int i = 0; i < 8; i++) adc_val[i] = 12'($urandom);

    // Reset and idle.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("rst_ss_n", SS_n, 1'b1);
    check("rst_sclk", SCLK, 1'b1);
    check("rst_mosi", MOSI, 1'b0);
    check("rst_cmplt", cnv_cmplt, 1'b0);
    check("rst_res", res, 12'h000);

    // Single conversion with hand-computed results.
    adc_val[5] = 12'hA5C;
    request(3'b101, 1);
    wait_cmplt("single");
    check("single_latency", cyc - acc_cyc, 1105);
    check("single_res", res, 12'hA5C);
    check("single_mosi", last_rcv, 16'h2800);

    // Back-to-back conversions with strt_cnv held high.
    @(negedge clk);
    chnnl = steps[0];
    strt_cnv = 1'b1;
    wait_cmplt("b2b0");
    last_c = cyc;
    for (int i = 1; i < 7; i++) begin
      chnnl = steps[i];
      wait_cmplt("b2b");
      check("b2b_spacing", cyc - last_c, LAT + 1);
      check("b2b_res", res, adc_val[steps[i]]);
      last_c = cyc;
    end
    strt_cnv = 1'b0;
    repeat (5) @(negedge clk);

    // Channel change mid-transaction must not affect the frames.
    request(3'b001, 1);
    repeat (300) @(negedge clk);
    chnnl = 3'b110;
    wait_cmplt("toggle");
    check("toggle_mosi", last_rcv, 16'h0800);
    check("toggle_res", res, adc_val[1]);

    // Reset during frame-2 SHIFT. Reset clears res and no strobe may follow.
    request(3'b011, 1);
    repeat (800) @(negedge clk);
    check("abort_mid_frame", SS_n, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ss_n", SS_n, 1'b1);
    check("abort_sclk", SCLK, 1'b1);
    check("abort_cmplt", cnv_cmplt, 1'b0);
    check("abort_res", res, 12'h000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    request(3'b011, 1);
    wait_cmplt("after_abort");
    check("after_abort_res", res, adc_val[3]);

    // Randomized conversions.
    for (int i = 0; i < 8; i++) begin
      ch = 3'($urandom);
      adc_val[ch] = 12'($urandom);
      request(ch, $urandom_range(1, 3));
      wait_cmplt("rand");
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

`ifdef ADC_ERR_EN
    // Bad status nibble sets err. The flag survives a clean conversion.
    err_nib = 4'h3;
    adc_val[2] = 12'h3C5;
    request(3'b010, 1);
    wait_cmplt("err_set");
    err_nib = 4'h0;
    check("err_set", err, 1'b1);
    check("err_res", res, 12'h3C5);
    repeat (3) @(negedge clk);
    request(3'b100, 1);
    wait_cmplt("err_hold");
    check("err_sticky", err, 1'b1);
`endif

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
